// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU issue controller: widths, opcodes and FSM encoding.
package alu_ctrl_pkg;

   localparam int DATA_W  = 13;
   localparam int INSTR_W = 16;
   localparam int REG_N   = 8;
   localparam int REG_AW  = 3;
   localparam int OP_W    = 3;
   localparam int IMM_W   = 7;

   typedef enum logic [OP_W-1:0] {
      OP_ADD  = 3'b000,
      OP_SUB  = 3'b001,
      OP_SLL  = 3'b010,
      OP_SRL  = 3'b011,
      OP_ADDI = 3'b100,
      OP_SUBI = 3'b101,
      OP_AND  = 3'b110,
      OP_OR   = 3'b111
   } op_e;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_READ  = 3'd1,
      ST_ISSUE = 3'd2,
      ST_WAIT  = 3'd3,
      ST_WB    = 3'd4
   } state_e;

   // Register-register forms take operand B from rt; all others use the immediate.
   function automatic logic op_uses_rt(input logic [OP_W-1:0] op);
      logic uses;
      uses = 1'b0;
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR: uses = 1'b1;
         default:                       uses = 1'b0;
      endcase
      return uses;
   endfunction

endpackage

// File: rtl/alu_regfile.sv
// Eight-entry register file: one write port, two operand read ports, one debug read port.
// Entry 0 is a constant zero, so writes addressed to it simply vanish.
module alu_regfile
   import alu_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              we_i,
   input  logic [REG_AW-1:0] waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [REG_AW-1:0] raddr_a_i,
   output logic [DATA_W-1:0] rdata_a_o,
   input  logic [REG_AW-1:0] raddr_b_i,
   output logic [DATA_W-1:0] rdata_b_o,
   input  logic [REG_AW-1:0] dbg_addr_i,
   output logic [DATA_W-1:0] dbg_data_o
);

   logic [DATA_W-1:0] rf_w [REG_N];

   genvar gi;
   generate
      for (gi = 0; gi < REG_N; gi++) begin : g_reg
         if (gi == 0) begin : g_zero
            assign rf_w[gi] = '0;
         end else begin : g_store
            logic [DATA_W-1:0] reg_q;
            always_ff @(posedge clk) begin
               if (rst) begin
                  reg_q <= '0;
               end else if (we_i && (waddr_i == REG_AW'(gi))) begin
                  reg_q <= wdata_i;
               end
            end
            assign rf_w[gi] = reg_q;
         end
      end
   endgenerate

   assign rdata_a_o  = rf_w[raddr_a_i];
   assign rdata_b_o  = rf_w[raddr_b_i];
   assign dbg_data_o = rf_w[dbg_addr_i];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller: accepts one instruction, reads operands, strobes an external ALU,
// captures its result and writes it back. Five cycles per instruction, no overlap.
module alu_issue_ctrl
   import alu_ctrl_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               instr_valid,
   output logic               instr_ready,
   input  logic [INSTR_W-1:0] instr,
   output logic [DATA_W-1:0]  alu_a,
   output logic [DATA_W-1:0]  alu_b,
   output logic [OP_W-1:0]    alu_sel,
   output logic               alu_start,
   input  logic [DATA_W-1:0]  alu_result,
   output logic               done,
   output logic [REG_AW-1:0]  wb_addr,
   output logic [DATA_W-1:0]  wb_data,
   input  logic [REG_AW-1:0]  dbg_addr,
   output logic [DATA_W-1:0]  dbg_data
);

   state_e             state_q;
   logic [INSTR_W-1:0] instr_q;
   logic [DATA_W-1:0]  alu_a_q;
   logic [DATA_W-1:0]  alu_b_q;
   logic [OP_W-1:0]    alu_sel_q;
   logic               alu_start_q;
   logic               done_q;
   logic [REG_AW-1:0]  wb_addr_q;
   logic [DATA_W-1:0]  wb_data_q;

   logic [OP_W-1:0]    op;
   logic [REG_AW-1:0]  rd;
   logic [REG_AW-1:0]  rs;
   logic [REG_AW-1:0]  rt;
   logic [IMM_W-1:0]   imm;
   logic [DATA_W-1:0]  rs_data;
   logic [DATA_W-1:0]  rt_data;
   logic [DATA_W-1:0]  alu_b_d;

   assign op  = instr_q[15:13];
   assign rd  = instr_q[12:10];
   assign rs  = instr_q[9:7];
   assign rt  = instr_q[6:4];
   assign imm = instr_q[6:0];

   assign alu_b_d = op_uses_rt(op) ? rt_data : {{(DATA_W-IMM_W){1'b0}}, imm};

   // Writeback happens on the WB->IDLE edge, so the next READ already sees it.
   alu_regfile u_regfile (
      .clk        (clk),
      .rst        (rst),
      .we_i       (state_q == ST_WB),
      .waddr_i    (wb_addr_q),
      .wdata_i    (wb_data_q),
      .raddr_a_i  (rs),
      .rdata_a_o  (rs_data),
      .raddr_b_i  (rt),
      .rdata_b_o  (rt_data),
      .dbg_addr_i (dbg_addr),
      .dbg_data_o (dbg_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         instr_q     <= '0;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         alu_sel_q   <= '0;
         alu_start_q <= 1'b0;
         done_q      <= 1'b0;
         wb_addr_q   <= '0;
         wb_data_q   <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (instr_valid) begin
                  instr_q <= instr;
                  state_q <= ST_READ;
               end
            end
            ST_READ: begin
               alu_a_q   <= rs_data;
               alu_b_q   <= alu_b_d;
               alu_sel_q <= op;
               state_q   <= ST_ISSUE;
            end
            ST_ISSUE: begin
               alu_start_q <= ~alu_start_q;
               state_q     <= ST_WAIT;
            end
            ST_WAIT: begin
               wb_data_q <= alu_result;
               wb_addr_q <= rd;
               state_q   <= ST_WB;
            end
            ST_WB: begin
               done_q  <= 1'b1;
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign instr_ready = (state_q == ST_IDLE);
   assign alu_a       = alu_a_q;
   assign alu_b       = alu_b_q;
   assign alu_sel     = alu_sel_q;
   assign alu_start   = alu_start_q;
   assign done        = done_q;
   assign wb_addr     = wb_addr_q;
   assign wb_data     = wb_data_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: a behavioural ALU drives alu_result, a scoreboard holds
// expected writebacks, and each scenario task checks timing and register contents.
module tb_alu_issue_ctrl;
   import alu_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        instr_valid = 1'b0;
   logic        instr_ready;
   logic [15:0] instr = '0;
   logic [12:0] alu_a, alu_b, alu_result, wb_data, dbg_data;
   logic [2:0]  alu_sel, wb_addr;
   logic [2:0]  dbg_addr = '0;
   logic        alu_start, done;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          cyc = 0;
   int          acc_cnt = 0;
   int          acc_cyc = 0;
   int          toggles = 0;
   logic        start_prev = 1'b0;
   logic [15:0] exp_q[$];
   logic [15:0] mon_e;
   logic [12:0] model_rf [8];

   always #5 clk = ~clk;

   alu_issue_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .instr       (instr),
      .alu_a       (alu_a),
      .alu_b       (alu_b),
      .alu_sel     (alu_sel),
      .alu_start   (alu_start),
      .alu_result  (alu_result),
      .done        (done),
      .wb_addr     (wb_addr),
      .wb_data     (wb_data),
      .dbg_addr    (dbg_addr),
      .dbg_data    (dbg_data)
   );

   function automatic logic [12:0] alu_fn(input logic [2:0] op, input logic [12:0] a,
                                          input logic [12:0] b);
      logic [12:0] r;
      case (op)
         3'b000, 3'b100: r = a + b;
         3'b001, 3'b101: r = a - b;
         3'b010:         r = a << b[3:0];
         3'b011:         r = a >> b[3:0];
         3'b110:         r = a & b;
         default:        r = a | b;
      endcase
      return r;
   endfunction

   assign alu_result = alu_fn(alu_sel, alu_a, alu_b);

   function automatic logic [15:0] enc_r(input logic [2:0] op, input logic [2:0] rd,
                                         input logic [2:0] rs, input logic [2:0] rt);
      return {op, rd, rs, rt, 4'b0000};
   endfunction

   function automatic logic [15:0] enc_i(input logic [2:0] op, input logic [2:0] rd,
                                         input logic [2:0] rs, input logic [6:0] imm);
      return {op, rd, rs, imm};
   endfunction

   // Compute the expected writeback from the bench register model and queue it.
   task automatic push_expect(input logic [15:0] ins);
      logic [2:0]  op, rd, rs, rt;
      logic [12:0] a, b, res;
      op = ins[15:13]; rd = ins[12:10]; rs = ins[9:7]; rt = ins[6:4];
      a = model_rf[rs];
      b = (op == 3'b000 || op == 3'b001 || op == 3'b110 || op == 3'b111) ?
          model_rf[rt] : {6'b0, ins[6:0]};
      res = alu_fn(op, a, b);
      exp_q.push_back({rd, res});
      if (rd != 3'd0) model_rf[rd] = res;
   endtask

   always @(posedge clk) begin
      if (!rst && instr_valid && instr_ready) begin
         acc_cnt = acc_cnt + 1;
         acc_cyc = cyc;
      end
      if (alu_start !== start_prev) toggles = toggles + 1;
      start_prev = alu_start;
      cyc = cyc + 1;
   end

   always @(negedge clk) begin
      if (!rst && done === 1'b1) begin
         n_cmp = n_cmp + 1;
         if (exp_q.size() == 0) begin
            n_bad = n_bad + 1;
            $display("FAIL unexpected_done: got done with wb_addr=%0d wb_data=%h, required no done",
                     wb_addr, wb_data);
         end else begin
            mon_e = exp_q.pop_front();
            if ({wb_addr, wb_data} !== mon_e) begin
               n_bad = n_bad + 1;
               $display("FAIL writeback: got addr=%0d data=%h, required addr=%0d data=%h",
                        wb_addr, wb_data, mon_e[15:13], mon_e[12:0]);
            end else begin
               $display("writeback addr=%0d data=%h ok", wb_addr, wb_data);
            end
         end
      end
   end

   // Drive one instruction, wait for its done; lat = cycles from accept edge to done.
   task automatic issue(input logic [15:0] ins, output int lat, output logic [12:0] dbg_wb);
      int start_acc;
      push_expect(ins);
      start_acc   = acc_cnt;
      instr       = ins;
      instr_valid = 1'b1;
      for (int k = 0; k < 20 && acc_cnt == start_acc; k++) begin
         @(posedge clk); #1;
      end
      instr_valid = 1'b0;
      instr       = 16'($urandom);
      lat         = -1;
      dbg_wb      = 'x;
      if (acc_cnt != start_acc) begin
         for (int k = 0; k < 12; k++) begin
            if (done === 1'b1) begin
               lat = cyc - acc_cyc;
               break;
            end
            dbg_wb = dbg_data;
            @(posedge clk); #1;
         end
      end
      $display("instr %h issued, latency %0d", ins, lat);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_cmp = n_cmp + 1;
      if ({instr_ready, done, alu_start} !== 3'b100) begin
         n_bad = n_bad + 1;
         $display("FAIL reset_ctrl: got ready/done/start=%b, required 100",
                  {instr_ready, done, alu_start});
      end
      n_cmp = n_cmp + 1;
      if ({alu_a, alu_b, alu_sel, wb_addr, wb_data} !== 45'd0) begin
         n_bad = n_bad + 1;
         $display("FAIL reset_data: got a=%h b=%h sel=%0d wa=%0d wd=%h, required all zero",
                  alu_a, alu_b, alu_sel, wb_addr, wb_data);
      end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_addi();
      int          lat;
      logic [12:0] dwb;
      dbg_addr = 3'd1;
      issue(16'h8405, lat, dwb);
      n_cmp = n_cmp + 1;
      if (lat != 5) begin
         n_bad = n_bad + 1;
         $display("FAIL addi_latency: got %0d, required 5", lat);
      end
      n_cmp = n_cmp + 1;
      if ({alu_sel, alu_b} !== {3'b100, 13'd5}) begin
         n_bad = n_bad + 1;
         $display("FAIL addi_operands: got sel=%b b=%0d, required sel=100 b=5", alu_sel, alu_b);
      end
      n_cmp = n_cmp + 1;
      if (dwb !== 13'd0) begin
         n_bad = n_bad + 1;
         $display("FAIL addi_dbg_in_wb: got %h, required 0", dwb);
      end
      n_cmp = n_cmp + 1;
      if (dbg_data !== 13'd5) begin
         n_bad = n_bad + 1;
         $display("FAIL addi_r1: got %h, required 5", dbg_data);
      end
      @(posedge clk); #1;
      n_cmp = n_cmp + 1;
      if (done !== 1'b0) begin
         n_bad = n_bad + 1;
         $display("FAIL done_width: got done=%b one cycle later, required 0", done);
      end
   endtask

   task automatic test_sub();
      int          lat;
      int          t0;
      logic [12:0] dwb;
      t0 = toggles;
      dbg_addr = 3'd2;
      issue(enc_r(3'b001, 3'd2, 3'd0, 3'd1), lat, dwb);
      @(posedge clk); #1;
      n_cmp = n_cmp + 1;
      if (dbg_data !== 13'h1FFB) begin
         n_bad = n_bad + 1;
         $display("FAIL sub_r2: got %h, required 1ffb", dbg_data);
      end
      n_cmp = n_cmp + 1;
      if (toggles - t0 != 1) begin
         n_bad = n_bad + 1;
         $display("FAIL start_toggles: got %0d, required 1", toggles - t0);
      end
   endtask

   task automatic test_back_to_back();
      int c1, c2, start_acc;
      logic [15:0] ia, ib;
      ia = 16'h4C83;                          // sll r3,r1,3
      ib = enc_i(3'b100, 3'd7, 3'd3, 7'd1);   // addi r7,r3,1
      push_expect(ia);
      start_acc   = acc_cnt;
      instr       = ia;
      instr_valid = 1'b1;
      for (int k = 0; k < 20 && acc_cnt == start_acc; k++) begin
         @(posedge clk); #1;
      end
      c1 = acc_cyc;
      push_expect(ib);
      instr = ib;
      @(posedge clk); #1;
      n_cmp = n_cmp + 1;
      if ({alu_sel, alu_b} !== {3'b010, 13'd3}) begin
         n_bad = n_bad + 1;
         $display("FAIL sll_operands: got sel=%b b=%0d, required sel=010 b=3", alu_sel, alu_b);
      end
      for (int k = 0; k < 20 && acc_cnt < start_acc + 2; k++) begin
         @(posedge clk); #1;
      end
      c2 = acc_cyc;
      instr_valid = 1'b0;
      n_cmp = n_cmp + 1;
      if (acc_cnt != start_acc + 2 || c2 - c1 != 5) begin
         n_bad = n_bad + 1;
         $display("FAIL accept_spacing: got %0d accepts %0d cycles apart, required 2 accepts 5 apart",
                  acc_cnt - start_acc, c2 - c1);
      end
      $display("back-to-back accepts at cycles %0d and %0d", c1, c2);
      for (int k = 0; k < 40 && exp_q.size() != 0; k++) begin
         @(posedge clk); #1;
      end
      n_cmp = n_cmp + 1;
      if (exp_q.size() != 0) begin
         n_bad = n_bad + 1;
         $display("FAIL drain: got %0d pending writebacks, required 0", exp_q.size());
      end
      dbg_addr = 3'd3;
      #1;
      n_cmp = n_cmp + 1;
      if (dbg_data !== 13'd40) begin
         n_bad = n_bad + 1;
         $display("FAIL sll_r3: got %0d, required 40", dbg_data);
      end
      dbg_addr = 3'd7;
      #1;
      n_cmp = n_cmp + 1;
      if (dbg_data !== 13'd41) begin
         n_bad = n_bad + 1;
         $display("FAIL dep_r7: got %0d, required 41", dbg_data);
      end
   endtask

   task automatic test_r0_write();
      int          lat;
      logic [12:0] dwb;
      issue(enc_i(3'b100, 3'd0, 3'd0, 7'd7), lat, dwb);
      n_cmp = n_cmp + 1;
      if (lat != 5 || wb_data !== 13'd7) begin
         n_bad = n_bad + 1;
         $display("FAIL r0_done: got latency=%0d wb_data=%0d, required 5 and 7", lat, wb_data);
      end
      dbg_addr = 3'd0;
      @(posedge clk); #1;
      n_cmp = n_cmp + 1;
      if (dbg_data !== 13'd0) begin
         n_bad = n_bad + 1;
         $display("FAIL r0_reads_zero: got %h, required 0", dbg_data);
      end
   endtask

   task automatic test_forward();
      int          lat;
      logic [12:0] dwb;
      issue(enc_r(3'b110, 3'd5, 3'd1, 3'd1), lat, dwb);
      issue(enc_r(3'b111, 3'd6, 3'd5, 3'd0), lat, dwb);
      @(posedge clk); #1;
      dbg_addr = 3'd5;
      #1;
      n_cmp = n_cmp + 1;
      if (dbg_data !== 13'd5) begin
         n_bad = n_bad + 1;
         $display("FAIL and_r5: got %0d, required 5", dbg_data);
      end
      dbg_addr = 3'd6;
      #1;
      n_cmp = n_cmp + 1;
      if (dbg_data !== 13'd5) begin
         n_bad = n_bad + 1;
         $display("FAIL or_r6: got %0d, required 5", dbg_data);
      end
   endtask

   task automatic test_reset_abort();
      int   start_acc;
      logic seen_done;
      start_acc   = acc_cnt;
      instr       = enc_i(3'b100, 3'd4, 3'd0, 7'd9);
      instr_valid = 1'b1;
      for (int k = 0; k < 20 && acc_cnt == start_acc; k++) begin
         @(posedge clk); #1;
      end
      instr_valid = 1'b0;
      @(posedge clk); #1;   // ISSUE
      @(posedge clk); #1;   // WAIT
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 8; i++) model_rf[i] = '0;
      n_cmp = n_cmp + 1;
      if (instr_ready !== 1'b1) begin
         n_bad = n_bad + 1;
         $display("FAIL abort_ready: got %b, required 1", instr_ready);
      end
      seen_done = 1'b0;
      for (int k = 0; k < 8; k++) begin
         if (done === 1'b1) seen_done = 1'b1;
         @(posedge clk); #1;
      end
      n_cmp = n_cmp + 1;
      if (seen_done !== 1'b0) begin
         n_bad = n_bad + 1;
         $display("FAIL abort_done: got a done pulse, required none");
      end
      dbg_addr = 3'd4;
      #1;
      n_cmp = n_cmp + 1;
      if (dbg_data !== 13'd0) begin
         n_bad = n_bad + 1;
         $display("FAIL abort_r4: got %0d, required 0", dbg_data);
      end
      dbg_addr = 3'd1;
      #1;
      n_cmp = n_cmp + 1;
      if (dbg_data !== 13'd0) begin
         n_bad = n_bad + 1;
         $display("FAIL reset_clears_r1: got %0d, required 0", dbg_data);
      end
   endtask

   initial begin
      for (int i = 0; i < 8; i++) model_rf[i] = '0;
      test_reset();
      test_addi();
      test_sub();
      test_back_to_back();
      test_r0_write();
      test_forward();
      test_reset_abort();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
